lzc_stream: RTL and testbench
=============================

# lzc_stream

Streaming leading-zero counter for multi-word operands. It accepts a frame of 1..MAX_WORDS beats, each WIDTH bits wide, MSB-first, over a valid/ready handshake. It returns the total count of leading zeros across the frame, or trailing zeros when the TRAILING parameter is set, together with the all-zero flag and the number of beats counted. It sits in the datapath front-end ahead of the normaliser. It replaces the fixed-depth counter and adds per-frame length (`in_last`), backpressure and a drain-after-early-exit mode.

## Interface
- WIDTH, 8: beat width in bits; power of 2, 4..64.
- MAX_WORDS, 4: maximum beats per frame, 1..256.
- TRAILING, 0: 1 counts trailing zeros (each beat bit-reversed before counting; frame still counted first-beat-first).
- CW, $clog2(WIDTH*MAX_WORDS+1): count width (derived, not overridden).
- NW, $clog2(MAX_WORDS+1): beat-count width (derived).

Ports:
- CLK  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low; clock CLK.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_data  in  WIDTH  beat data.
- in_last  in  1  final beat of frame.
- in_mode  in  1  1 = early-exit frame; sampled on first beat only.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  result consumer ready.
- out_count  out  CW  zero count.
- out_allzero  out  1  no set bit found in counted beats.
- out_words  out  NW  beats counted (excludes drained beats).

## Operation
- States: ACC (counting), DRAIN (discarding the rest of an early-exited frame). Reset state is ACC.
- Per accepted beat in ACC:
  - While no set bit has been found, `count += (beat==0) ? WIDTH : lz(beat)`.
  - After the first nonzero beat, `count` freezes. Later beats only increment `words` (normal mode).
- A frame terminates on the accepted beat that meets any of these:
  - `in_last`.
  - `words` reaches MAX_WORDS (forced end; the next beat starts a new frame).
  - The first nonzero beat, when `mode_r`=1 and the macro is enabled.
- On termination:
  - Load `out_count`, `out_allzero` and `out_words` (including the terminating beat), set `out_valid`.
  - Clear the accumulators.
  - Early exit without `in_last` → DRAIN; otherwise stay in ACC.
- DRAIN:
  - `in_ready`=1.
  - Beats are discarded.
  - The beat with `in_last`, or the beat that reaches MAX_WORDS total beats, → ACC.
- `in_ready` = (state==DRAIN) | ~out_valid | out_ready.
- Result slot: the load has priority. A pop and a load in the same cycle leave `out_valid`=1 with the new result.
- `mode_r` is latched from `in_mode` on the first beat of each frame. Changes to `in_mode` mid-frame are ignored.
- Arithmetic:
  - `count` is CW bits and never saturates; the maximum is WIDTH*MAX_WORDS.
  - `lz()` is a log2(WIDTH)-level priority tree.
- Reset mid-frame: the partial frame is discarded, the pending result is lost, and the state returns to ACC.

## Timing
- Reset values: out_valid=0, out_count=0, out_allzero=0, out_words=0, in_ready=1, state=ACC, accumulators 0.
- Latency: `out_valid` rises on the clock edge after the terminating beat's handshake (1 cycle). Throughput is 1 beat/cycle.
- Result outputs are registered and remain stable while out_valid & ~out_ready.
- `in_ready` is combinational from `out_ready` (single result slot, no skid).
- The output updates only on load, never on pop alone. Values after a pop are don't-care, with out_valid=0.

## Configuration
- LZC_EARLY_EXIT_EN defined:
  - `in_mode`=1 frames terminate on the first nonzero beat.
  - The remaining beats drain via DRAIN.
- LZC_EARLY_EXIT_EN undefined:
  - `in_mode` is ignored and `mode_r` is tied to 0.
  - DRAIN logic is removed.
  - Every frame ends on `in_last` or MAX_WORDS.
  - Port list unchanged.

## Test plan
All scenarios use WIDTH=8, MAX_WORDS=4, TRAILING=0.
- Normal: 0x00,0x00,0x10,0xFF(last), out_ready=1 → count=19, allzero=0, words=4, out_valid 1 cycle after beat 4.
- All-zero: 0x00×4 with last on beat 4 → count=32, allzero=1, words=4.
- Early exit (macro on): mode=1, 0x00,0x01,0xAA,0x55(last) → count=15, words=2 one cycle after beat 2. Beats 3–4 accepted with no output. The next frame, 0x80(last), gives count=0, words=1. With the macro off, the same input gives count=15, words=4.
- Forced end: 0x00×5 without last, out_ready=1 → first result count=32, words=4. The 5th beat opens a new frame.
- Backpressure: out_ready=0, frame 0x40(last) → out_valid=1, count=1, in_ready=0. Frame B is stalled and the outputs stay stable. Raise out_ready for 1 cycle → pop, B's beat is accepted the same cycle, and B's result loads next.
- Reset mid-frame: 2 zero beats, then rst_n low for 1 cycle, then 0x01(last) → count=7, words=1.

Source files
------------

// File: rtl/lzc_stream_if.sv
// lzc_stream beat/result handshake bundle.
// master drives beats and consumes results; slave is the counter.
interface lzc_stream_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 4
);
  localparam int CW = $clog2(WIDTH*MAX_WORDS+1);
  localparam int NW = $clog2(MAX_WORDS+1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_allzero;
  logic [NW-1:0]    out_words;

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_allzero, out_words
  );

  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_allzero, out_words
  );
endinterface

// File: rtl/lzc_stream.sv
// Streaming multi-beat leading/trailing zero counter, one result slot.
// LZC_EARLY_EXIT_EN enables in_mode early-exit frames and the DRAIN state.
module lzc_stream #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 4,
  parameter int TRAILING  = 0
) (
  input logic         CLK,
  input logic         rst_n,
  lzc_stream_if.slave bus
);
  localparam int CW = $clog2(WIDTH*MAX_WORDS+1);
  localparam int NW = $clog2(MAX_WORDS+1);
  localparam int LW = $clog2(WIDTH);

  logic [WIDTH-1:0] beat;
  logic [WIDTH-1:0] norm;
  logic [LW-1:0]    lz;
  logic [CW-1:0]    beat_lz;
  logic [CW-1:0]    cnt_nx;
  logic [NW-1:0]    words_nx;
  logic             beat_zero;
  logic             found_nx;
  logic             fire;
  logic             at_max;
  logic             early;
  logic             term;
  logic             go_drain;
  logic             drain;
  logic             mode_eff;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] words_q, words_d;
  logic          found_q, found_d;
  logic          ov_q, ov_d;
  logic [CW-1:0] oc_q, oc_d;
  logic          oa_q, oa_d;
  logic [NW-1:0] ow_q, ow_d;

`ifdef LZC_EARLY_EXIT_EN
  localparam logic [0:0] ACC   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0] state_q, state_d;
  logic       mode_q, mode_d;
  logic       first;

  assign first    = words_q == '0;
  assign drain    = state_q == DRAIN;
  assign mode_eff = first ? bus.in_mode : mode_q;
`else
  assign drain    = 1'b0;
  assign mode_eff = 1'b0;
`endif

  always_comb begin
    beat = bus.in_data;
    if (TRAILING != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        beat[i] = bus.in_data[WIDTH-1-i];
      end
    end
  end

  // Binary normalisation tree: each level tests the top half of what is left.
  always_comb begin
    norm = beat;
    lz   = '0;
    for (int l = LW-1; l >= 0; l--) begin
      if ((norm >> (WIDTH - (1 << l))) == '0) begin
        lz[l] = 1'b1;
        norm  = norm << (1 << l);
      end
    end
  end

  assign beat_zero = ~|beat;
  assign beat_lz   = beat_zero ? CW'(WIDTH) : CW'(lz);
  assign cnt_nx    = found_q ? cnt_q : cnt_q + beat_lz;
  assign found_nx  = found_q | ~beat_zero;
  assign words_nx  = words_q + NW'(1);
  assign at_max    = words_nx == NW'(MAX_WORDS);
  assign early     = mode_eff & ~beat_zero;
  assign term      = bus.in_last | at_max | early;
  assign go_drain  = early & ~bus.in_last & ~at_max;

  assign bus.in_ready    = drain | ~ov_q | bus.out_ready;
  assign fire            = bus.in_valid & bus.in_ready;
  assign bus.out_valid   = ov_q;
  assign bus.out_count   = oc_q;
  assign bus.out_allzero = oa_q;
  assign bus.out_words   = ow_q;

  always_comb begin
    cnt_d   = cnt_q;
    words_d = words_q;
    found_d = found_q;
    ov_d    = ov_q & ~bus.out_ready;
    oc_d    = oc_q;
    oa_d    = oa_q;
    ow_d    = ow_q;
`ifdef LZC_EARLY_EXIT_EN
    state_d = state_q;
    mode_d  = mode_q;
`endif
    unique case (1'b1)
      fire & drain: begin
        words_d = (bus.in_last | at_max) ? '0 : words_nx;
`ifdef LZC_EARLY_EXIT_EN
        state_d = (bus.in_last | at_max) ? ACC : DRAIN;
`endif
      end
      fire & ~drain & term: begin
        ov_d    = 1'b1;
        oc_d    = cnt_nx;
        oa_d    = ~found_nx;
        ow_d    = words_nx;
        cnt_d   = '0;
        found_d = 1'b0;
        // Drain keeps the beat tally so the frame still ends at MAX_WORDS.
        words_d = go_drain ? words_nx : '0;
`ifdef LZC_EARLY_EXIT_EN
        state_d = go_drain ? DRAIN : ACC;
`endif
      end
      fire & ~drain & ~term: begin
        cnt_d   = cnt_nx;
        words_d = words_nx;
        found_d = found_nx;
`ifdef LZC_EARLY_EXIT_EN
        if (first) mode_d = bus.in_mode;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      words_q <= '0;
      found_q <= 1'b0;
      ov_q    <= 1'b0;
      oc_q    <= '0;
      oa_q    <= 1'b0;
      ow_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      words_q <= words_d;
      found_q <= found_d;
      ov_q    <= ov_d;
      oc_q    <= oc_d;
      oa_q    <= oa_d;
      ow_q    <= ow_d;
    end
  end

`ifdef LZC_EARLY_EXIT_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end
`endif
endmodule

// File: tb/tb_lzc_stream.sv
// Bench for lzc_stream: frame-level model plus directed frames.
// Expectations follow LZC_EARLY_EXIT_EN when it is defined.
module tb_lzc_stream;
  localparam int W    = 8;
  localparam int MAXW = 4;

  logic CLK;
  logic rst_n;
  int   checks;
  int   errors;

  lzc_stream_if #(.WIDTH(W), .MAX_WORDS(MAXW)) bus ();

  lzc_stream #(
    .WIDTH(W),
    .MAX_WORDS(MAXW),
    .TRAILING(0)
  ) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lead_zeros(input logic [W-1:0] v);
    for (int i = W-1; i >= 0; i--) begin
      if (v[i]) return W-1-i;
    end
    return W;
  endfunction

  // Frame model: accumulators per frame and the single expected result slot.
  int m_cnt;
  int m_words;
  bit m_found;
  bit m_mode;
  bit m_drain;
  bit e_valid;
  int e_cnt;
  int e_words;
  bit e_allz;

  always @(posedge CLK or negedge rst_n) begin : model
    int  nc, nw;
    bit  nf, md, early, term, rdy, dr;
    if (!rst_n) begin
      m_cnt   <= 0;
      m_words <= 0;
      m_found <= 0;
      m_mode  <= 0;
      m_drain <= 0;
      e_valid <= 0;
      e_cnt   <= 0;
      e_words <= 0;
      e_allz  <= 0;
    end else begin
      rdy = m_drain || !e_valid || bus.out_ready;
      if (bus.out_ready) e_valid <= 0;
      if (bus.in_valid && rdy) begin
        nw = m_words + 1;
        if (m_drain) begin
          if (bus.in_last || nw == MAXW) begin
            m_drain <= 0;
            m_words <= 0;
          end else begin
            m_words <= nw;
          end
        end else begin
          md = (m_words == 0) ? bus.in_mode : m_mode;
`ifndef LZC_EARLY_EXIT_EN
          md = 0;
`endif
          nc    = m_found ? m_cnt : m_cnt + lead_zeros(bus.in_data);
          nf    = m_found || (bus.in_data != 0);
          early = md && (bus.in_data != 0);
          term  = bus.in_last || nw == MAXW || early;
          if (m_words == 0) m_mode <= bus.in_mode;
          if (term) begin
            dr      = early && !bus.in_last && nw != MAXW;
            e_valid <= 1;
            e_cnt   <= nc;
            e_words <= nw;
            e_allz  <= !nf;
            m_cnt   <= 0;
            m_found <= 0;
            m_drain <= dr;
            m_words <= dr ? nw : 0;
          end else begin
            m_cnt   <= nc;
            m_found <= nf;
            m_words <= nw;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (rst_n) begin
      chk("out_valid", bus.out_valid, e_valid);
      chk("in_ready", bus.in_ready,
          (m_drain || !e_valid || bus.out_ready) ? 1 : 0);
      if (e_valid) begin
        chk("out_count", bus.out_count, e_cnt);
        chk("out_allzero", bus.out_allzero, e_allz);
        chk("out_words", bus.out_words, e_words);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit last, input bit mode);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_mode  = mode;
    @(negedge CLK);
    while (!bus.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 expected 1 at %0t", $time);
    end
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_res(input string name, input int c, input int a,
                         input int w);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_count"}, bus.out_count, c);
    chk({name, "_allzero"}, bus.out_allzero, a);
    chk({name, "_words"}, bus.out_words, w);
    chk({name, "_model"}, e_cnt, c);
  endtask

  task automatic idle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_allzero", bus.out_allzero, 0);
    chk("rst_out_words", bus.out_words, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    idle();
    rst_n = 1'b1;
    idle();

    send(8'h00, 0, 0);
    send(8'h00, 0, 0);
    send(8'h10, 0, 0);
    send(8'hFF, 1, 0);
    chk_res("normal", 19, 0, 4);

    for (int i = 0; i < 4; i++) send(8'h00, i == 3, 0);
    chk_res("allzero", 32, 1, 4);

    send(8'h00, 0, 1);
    send(8'h01, 0, 0);
`ifdef LZC_EARLY_EXIT_EN
    chk_res("early", 15, 0, 2);
    send(8'hAA, 0, 0);
    send(8'h55, 1, 0);
    chk("early_drained", bus.out_valid, 0);
`else
    send(8'hAA, 0, 0);
    send(8'h55, 1, 0);
    chk_res("noearly", 15, 0, 4);
`endif
    send(8'h80, 1, 0);
    chk_res("after_early", 0, 0, 1);

    for (int i = 0; i < 4; i++) send(8'h00, 0, 0);
    chk_res("forced", 32, 1, 4);
    send(8'h00, 0, 0);
    send(8'h01, 1, 0);
    chk_res("forced_next", 15, 0, 2);

    idle();
    bus.out_ready = 1'b0;
    send(8'h40, 1, 0);
    chk_res("bp_a", 1, 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h20;
    bus.in_last  = 1'b1;
    bus.in_mode  = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_count", bus.out_count, 1);
      chk("bp_hold_valid", bus.out_valid, 1);
    end
    idle();
    bus.out_ready = 1'b1;
    idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk_res("bp_b", 2, 0, 1);
    bus.out_ready = 1'b1;
    idle();

    send(8'h00, 0, 0);
    send(8'h00, 0, 0);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    send(8'h01, 1, 0);
    chk_res("rst_mid", 7, 0, 1);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
